id_exe_ctrl: RTL
================

# id_exe_ctrl

Instruction-decode control and ID/EXE pipeline register for the ARM-subset core. It decodes a fetched instruction into `exe_command` and the memory, writeback and branch controls, and evaluates the condition field against the NZCV status register. It owns that status register: it captures ALU `status_bits` and feeds the carry back to the ALU through `status_reg_out[29]`. The block sits between the instruction-fetch register and the EXE stage.

## Interface
- No parameters; widths are fixed by the ISA.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset (one clock, async active-low reset).
- `instr_in` in 32: instruction from the IF/ID register.
- `instr_valid` in 1: `instr_in` holds a real instruction.
- `pc_in` in 32: PC+4 of `instr_in`.
- `stall` in 1: hazard unit holds the ID/EXE register.
- `flush` in 1: a taken branch kills the instruction in ID.
- `status_bits_in` in 4: ALU `{N,Z,C,V}` from the EXE instruction.
- `status_we` in 1: the EXE instruction has S=1 and is valid.
- `exe_command` out 4: ALU opcode.
- `mem_read`, `mem_write`, `wb_en`, `branch_en`, `s_bit`, `imm` out 1 each: controls.
- `rn`, `rd` out 4 each: register fields.
- `shift_operand` out 12: `instr[11:0]`.
- `signed_imm24` out 24: `instr[23:0]`.
- `pc_out` out 32: registered `pc_in`.
- `valid_out` out 1: the EXE slot holds a live instruction.
- `illegal_op` out 1: the EXE slot holds an undefined opcode.
- `status_reg_out` out 32: N at bit 31, Z at bit 30, C at bit 29, V at bit 28; all other bits are 0.

## Operation
- Mode comes from `instr[27:26]`: 00 = data-processing, 01 = memory, 10 = branch, 11 = illegal.
- Data-processing opcode map (`instr[24:21]` to `exe_command`):
  - AND 0000→0110, EOR 0001→1000, SUB 0010→0100, ADD 0100→0010, ADC 0101→0011
  - SBC 0110→0101, TST 1000→0110, CMP 1010→0100, ORR 1100→0111, MOV 1101→0001, MVN 1111→1001
  - Any other opcode sets `illegal_op`; controls are zeroed and `exe_command` = 0000.
- Data-processing controls:
  - `wb_en` = 1 except for TST and CMP.
  - TST and CMP force `s_bit` = 1.
  - Otherwise `s_bit` = `instr[20]`.
  - `imm` = `instr[25]`.
- Memory mode: `exe_command` = 0010 (add base + offset), `s_bit` = 0.
  - `instr[20]` = 1 (LDR): `mem_read` = 1, `wb_en` = 1.
  - `instr[20]` = 0 (STR): `mem_write` = 1.
- Branch mode: `branch_en` = 1, `exe_command` = 0000, no writeback.
- Condition check on `instr[31:28]`:
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V
  - HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1
  - 1111 always fails.
- A failed condition or `instr_valid` = 0 makes the captured slot a bubble: `valid_out`, `wb_en`, `mem_read`, `mem_write`, `branch_en` and `s_bit` are all 0.
- Status register:
  - Loads `status_bits_in` on the clock edge when `status_we` = 1.
  - Holds otherwise.
  - Is never affected by `stall` or `flush`.

## Timing
- Reset: every output is 0, including `status_reg_out` = 0x00000000 and `exe_command` = 0000.
- Latency: decode is combinational; outputs are registered, so `instr_in` at edge k appears at the outputs after edge k.
- Update priority per edge is `flush`, then `stall`, then load:
  - `flush` = 1: load a bubble and drop the ID instruction. `flush` beats `stall`.
  - `stall` = 1 alone: hold all ID/EXE outputs unchanged.
- The status register and the ID/EXE register update on the same edge, independently.
- A mid-operation `rst_n` assertion clears all state immediately, without waiting for `clk`; the first capture occurs on the first clock edge after deassertion.

## Configuration
- `STATUS_FWD_EN` defined: when `status_we` = 1, condition evaluation uses `status_bits_in` (the flags being written this cycle). A back-to-back flag-setter followed by a conditional instruction therefore needs no stall.
- Not defined: conditions read only `status_reg_out`. The hazard unit must stall a conditional instruction that directly follows an S=1 instruction.
- `status_reg_out` timing is identical in both builds.

## Structure
- Shared package `cpu_pkg` holds:
  - the EXE command constants (MOV, MVN, ADD, ADC, SUB, SBC, AND, ORR, EOR)
  - the mode codes
  - the ARM opcode constants
  - the 4-bit condition-code enum
  - the NZCV bit-index constants 31, 30, 29, 28
- One combinational sub-module, `cond_check`: inputs are cond (4 bits) and nzcv (4 bits); output is `pass`.
- Top-level registers: the status register and the ID/EXE register.

## Test plan
- Reset, then ADD R1,R2,R3 with cond AL (`0xE0821003`) and `instr_valid` = 1 → after one edge: `exe_command` = 0010, `wb_en` = 1, `rd` = 1, `rn` = 2, `valid_out` = 1.
- CMP with `status_we` = 1 and `status_bits_in` = 0100, then BEQ on the next cycle:
  - With `STATUS_FWD_EN`: BEQ yields `branch_en` = 1.
  - Without it, and no stall: BEQ yields a bubble.
  - In both builds, `status_reg_out` = 0x40000000.
- LDR (`instr[27:26]` = 01, L = 1) → `mem_read` = 1, `wb_en` = 1, `exe_command` = 0010. The STR variant → `mem_write` = 1, `wb_en` = 0.
- `stall` and `flush` asserted together with a valid MOV → bubble captured (`valid_out` = 0). `stall` alone → previous outputs held for 3 cycles.
- Opcode 0011 in data-processing mode → `illegal_op` = 1, `wb_en` = 0, `exe_command` = 0000.
- C set via `status_we` with `status_bits_in` = 0010 → `status_reg_out[29]` = 1 on the next cycle. Assert `rst_n` low between edges → `status_reg_out` = 0 before the next edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared decode constants and the ID/EXE bundle for the ARM-subset core.
package cpu_pkg;

  localparam logic [3:0] EXE_NOP = 4'b0000;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;
  localparam logic [1:0] MODE_ILL = 2'b11;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  typedef enum logic [3:0] {
    COND_EQ, COND_NE, COND_CS, COND_CC,
    COND_MI, COND_PL, COND_VS, COND_VC,
    COND_HI, COND_LS, COND_GE, COND_LT,
    COND_GT, COND_LE, COND_AL, COND_NV
  } cond_e;

  localparam int N_BIT = 31;
  localparam int Z_BIT = 30;
  localparam int C_BIT = 29;
  localparam int V_BIT = 28;

  typedef struct packed {
    logic [3:0]  exe_command;
    logic        mem_read;
    logic        mem_write;
    logic        wb_en;
    logic        branch_en;
    logic        s_bit;
    logic        imm;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm24;
    logic [31:0] pc;
    logic        valid;
    logic        illegal;
  } id_ex_t;

endpackage

// File: rtl/id_exe_ctrl_cond_check.sv
// ARM condition-field evaluator against an NZCV nibble.
module cond_check
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  assign {n, z, c, v} = nzcv;

  always_comb begin
    pass = 1'b0;
    unique case (cond_e'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c & !z;
      COND_LS: pass = !c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/id_exe_ctrl.sv
// ID decode, NZCV status register and ID/EXE pipeline register.
// Define STATUS_FWD_EN to evaluate conditions on flags written this cycle.
module id_exe_ctrl
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_in,
  input  logic        instr_valid,
  input  logic [31:0] pc_in,
  input  logic        stall,
  input  logic        flush,
  input  logic [3:0]  status_bits_in,
  input  logic        status_we,
  output logic [3:0]  exe_command,
  output logic        mem_read,
  output logic        mem_write,
  output logic        wb_en,
  output logic        branch_en,
  output logic        s_bit,
  output logic        imm,
  output logic [3:0]  rn,
  output logic [3:0]  rd,
  output logic [11:0] shift_operand,
  output logic [23:0] signed_imm24,
  output logic [31:0] pc_out,
  output logic        valid_out,
  output logic        illegal_op,
  output logic [31:0] status_reg_out
);

  logic [3:0] nzcv_q;
  logic [3:0] cond_flags;
  logic       cond_pass;
  logic [1:0] mode;
  logic [3:0] op;
  id_ex_t     dec;
  id_ex_t     id_ex_q;

`ifdef STATUS_FWD_EN
  assign cond_flags = status_we ? status_bits_in : nzcv_q;
`else
  assign cond_flags = nzcv_q;
`endif

  cond_check u_cond (
    .cond (instr_in[31:28]),
    .nzcv (cond_flags),
    .pass (cond_pass)
  );

  assign mode = instr_in[27:26];
  assign op   = instr_in[24:21];

  always_comb begin
    dec               = '0;
    dec.rn            = instr_in[19:16];
    dec.rd            = instr_in[15:12];
    dec.shift_operand = instr_in[11:0];
    dec.signed_imm24  = instr_in[23:0];
    dec.pc            = pc_in;
    unique case (mode)
      MODE_DP: begin
        dec.imm   = instr_in[25];
        dec.wb_en = 1'b1;
        dec.s_bit = instr_in[20];
        unique case (op)
          OP_AND: dec.exe_command = EXE_AND;
          OP_EOR: dec.exe_command = EXE_EOR;
          OP_SUB: dec.exe_command = EXE_SUB;
          OP_ADD: dec.exe_command = EXE_ADD;
          OP_ADC: dec.exe_command = EXE_ADC;
          OP_SBC: dec.exe_command = EXE_SBC;
          OP_ORR: dec.exe_command = EXE_ORR;
          OP_MOV: dec.exe_command = EXE_MOV;
          OP_MVN: dec.exe_command = EXE_MVN;
          OP_TST: begin
            dec.exe_command = EXE_AND;
            dec.wb_en       = 1'b0;
            dec.s_bit       = 1'b1;
          end
          OP_CMP: begin
            dec.exe_command = EXE_SUB;
            dec.wb_en       = 1'b0;
            dec.s_bit       = 1'b1;
          end
          default: begin
            dec.illegal = 1'b1;
            dec.imm     = 1'b0;
            dec.wb_en   = 1'b0;
            dec.s_bit   = 1'b0;
          end
        endcase
      end
      MODE_MEM: begin
        dec.exe_command = EXE_ADD;
        dec.mem_read    = instr_in[20];
        dec.wb_en       = instr_in[20];
        dec.mem_write   = !instr_in[20];
      end
      MODE_BR: dec.branch_en = 1'b1;
      default: dec.illegal = 1'b1;
    endcase
    // Killed slots keep their fields but may not touch architectural state.
    if (instr_valid && cond_pass) begin
      dec.valid = 1'b1;
    end else begin
      dec.wb_en     = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
      dec.branch_en = 1'b0;
      dec.s_bit     = 1'b0;
      dec.illegal   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex_q <= '0;
    end else if (flush) begin
      id_ex_q <= '0;
    end else if (!stall) begin
      id_ex_q <= dec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nzcv_q <= '0;
    end else if (status_we) begin
      nzcv_q <= status_bits_in;
    end
  end

  always_comb begin
    status_reg_out        = '0;
    status_reg_out[N_BIT] = nzcv_q[3];
    status_reg_out[Z_BIT] = nzcv_q[2];
    status_reg_out[C_BIT] = nzcv_q[1];
    status_reg_out[V_BIT] = nzcv_q[0];
  end

  assign exe_command   = id_ex_q.exe_command;
  assign mem_read      = id_ex_q.mem_read;
  assign mem_write     = id_ex_q.mem_write;
  assign wb_en         = id_ex_q.wb_en;
  assign branch_en     = id_ex_q.branch_en;
  assign s_bit         = id_ex_q.s_bit;
  assign imm           = id_ex_q.imm;
  assign rn            = id_ex_q.rn;
  assign rd            = id_ex_q.rd;
  assign shift_operand = id_ex_q.shift_operand;
  assign signed_imm24  = id_ex_q.signed_imm24;
  assign pc_out        = id_ex_q.pc;
  assign valid_out     = id_ex_q.valid;
  assign illegal_op    = id_ex_q.illegal;

endmodule
